// File: rtl/data_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_stream_pkg
// Description : Shared state encodings, constants and byte-order helper for
//               the UART<->SDRAM read/write stream controllers.
// Revision    : 1.0 - initial release
// ============================================================================
package data_stream_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_HIGH = 2'd1,
        S_DONE = 2'd2
    } ws_state_e;

    localparam int         c_DATA_CNT_DEFAULT = 1024;
    localparam logic [7:0] c_PAD_BYTE         = 8'h00;

    // First byte on the wire lands in the upper half of the word.
    function automatic logic [15:0] pack_word(input logic [7:0] first_byte,
                                              input logic [7:0] second_byte);
        return {first_byte, second_byte};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ws_idle_timer.sv
`default_nettype none
// ============================================================================
// Module      : ws_idle_timer
// Description : Idle-cycle counter; pulses flush after TIMEOUT_CNT enabled
//               cycles without a clear.
// Revision    : 1.0 - initial release
// ============================================================================
module ws_idle_timer #(
    parameter int TIMEOUT_CNT = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic flush
);

    localparam int c_CNT_W = $clog2(TIMEOUT_CNT + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CNT - 1);

    logic [c_CNT_W-1:0] r_idle;

    assign flush = enable && !clear && (r_idle == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle <= '0;
        end else if (!enable || clear || flush) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_writestream.sv
`default_nettype none
// ============================================================================
// Module      : data_writestream
// Description : Packs UART byte pairs into 16-bit words and strobes them into
//               the SDRAM write FIFO until DATA_CNT words are stored.
//               Optional idle flush of a half word: WRITESTREAM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module data_writestream
    import data_stream_pkg::*;
#(
    parameter int DATA_CNT    = c_DATA_CNT_DEFAULT,
    parameter int CNT_W       = 23,
    parameter int TIMEOUT_CNT = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rxd_flag,
    input  logic [7:0]       rxd_data,
    input  logic             wr_full,
    input  logic             stream_clr,
    output logic             sys_wr,
    output logic [15:0]      sys_data_in,
    output logic [CNT_W-1:0] word_cnt,
    output logic             write_done,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] c_LAST_WORD = CNT_W'(DATA_CNT - 1);

    ws_state_e        r_state;
    ws_state_e        w_state_nxt;
    logic [7:0]       r_byte;
    logic             r_sys_wr;
    logic [15:0]      r_data;
    logic [CNT_W-1:0] r_cnt;
    logic             r_overflow;
    logic             w_load_byte;
    logic             w_complete;
    logic             w_write;
    logic [7:0]       w_second;
    logic             w_flush;

`ifdef WRITESTREAM_TIMEOUT_EN
    ws_idle_timer #(
        .TIMEOUT_CNT(TIMEOUT_CNT)
    ) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (r_state == S_HIGH),
        .clear  (rxd_flag || stream_clr),
        .flush  (w_flush)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = TIMEOUT_CNT[0];
    assign w_flush          = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOW;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_byte = 1'b0;
        w_complete  = 1'b0;
        w_second    = rxd_data;
        case (r_state)
            S_LOW: begin
                if (rxd_flag) begin
                    w_load_byte = 1'b1;
                    w_state_nxt = S_HIGH;
                end
            end
            S_HIGH: begin
                if (rxd_flag) begin
                    w_complete = 1'b1;
                end else if (w_flush) begin
                    w_complete = 1'b1;
                    w_second   = c_PAD_BYTE;
                end
                if (w_complete) begin
                    // A dropped word does not count towards the stream length.
                    w_state_nxt = (!wr_full && (r_cnt == c_LAST_WORD)) ? S_DONE : S_LOW;
                end
            end
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_LOW;
        endcase
        if (stream_clr) begin
            w_state_nxt = S_LOW;
            w_load_byte = 1'b0;
            w_complete  = 1'b0;
        end
    end

    assign w_write = w_complete && !wr_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte     <= 8'h00;
            r_sys_wr   <= 1'b0;
            r_data     <= 16'h0000;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_sys_wr <= w_write;
            if (stream_clr) begin
                r_byte <= 8'h00;
            end else if (w_load_byte) begin
                r_byte <= rxd_data;
            end
            if (w_write) begin
                r_data <= pack_word(r_byte, w_second);
            end
            if (stream_clr) begin
                r_cnt      <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_write) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_complete && wr_full) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign sys_wr      = r_sys_wr;
    assign sys_data_in = r_data;
    assign word_cnt    = r_cnt;
    assign write_done  = (r_state == S_DONE);
    assign overflow    = r_overflow;

endmodule
`default_nettype wire
